// File: rtl/shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// shift_reg_pkg
// Shared definitions for the universal shift register slice:
//   - MODE_* : operation-select encodings for Mode_In (3 bits)
//   - state_e : control state (IDLE / BURST)
//   - clamp_burst_len : limits a requested burst length to the register width
// ---------------------------------------------------------------------------
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHR  = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_ROR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_LOAD = 3'd5;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // A burst never needs more shifts than there are bits in the register.
  function automatic int unsigned clamp_burst_len(input int unsigned len,
                                                  input int unsigned max_len);
    if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/shift_burst_counter.sv
// ---------------------------------------------------------------------------
// shift_burst_counter
// Holds the number of burst shifts still to perform.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   load_i        : capture clamped len_i (burst start, already enable-qualified)
//   dec_i         : count one shift (enable-qualified)
//   len_i         : requested burst length
//   load_zero_o   : requested length is zero (burst completes immediately)
//   last_o        : the shift being performed now is the final one
// ---------------------------------------------------------------------------
module shift_burst_counter
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             load_zero_o,
  output logic             last_o
);

  localparam int unsigned MAX_LEN = WIDTH;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] len_clamped_s;
  int unsigned      len_ext_s;

  assign len_ext_s     = 32'(len_i);
  assign len_clamped_s = CNT_W'(clamp_burst_len(len_ext_s, MAX_LEN));
  assign load_zero_o   = (len_i == {CNT_W{1'b0}});
  assign last_o        = (count_q == CNT_W'(1));

  // Next count: load wins over decrement; never wrap below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = len_clamped_s;
    end else if (dec_i && (count_q != {CNT_W{1'b0}})) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// ---------------------------------------------------------------------------
// universal_shift_register
// Hold / shift / rotate / parallel-load register with an LSB-first burst mode.
//   Clk_In, Reset_In   : clock, asynchronous active-high reset
//   Enable_In          : clock enable (freezes register, counter and state)
//   Mode_In            : operation select while idle (see shift_reg_pkg)
//   Serial_Msb_In      : fill bit for right shifts (including burst)
//   Serial_Lsb_In      : fill bit for left shifts
//   Parallel_Data_In   : load data (MODE_LOAD and burst start)
//   Burst_Start_In     : start a burst (honoured in IDLE only)
//   Burst_Len_In       : number of burst shifts (clamped to WIDTH)
//   Parallel_Data_Out  : register contents
//   Serial_Lsb_Out     : register bit 0 (next bit out during a burst)
//   Serial_Msb_Out     : register bit WIDTH-1
//   Busy_Out           : high while a burst is in progress
//   Done_Out           : one-cycle pulse when a burst completes
// ---------------------------------------------------------------------------
module universal_shift_register
  import shift_reg_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             Enable_In,
  input  logic [2:0]       Mode_In,
  input  logic             Serial_Msb_In,
  input  logic             Serial_Lsb_In,
  input  logic [WIDTH-1:0] Parallel_Data_In,
  input  logic             Burst_Start_In,
  input  logic [CNT_W-1:0] Burst_Len_In,
  output logic [WIDTH-1:0] Parallel_Data_Out,
  output logic             Serial_Lsb_Out,
  output logic             Serial_Msb_Out,
  output logic             Busy_Out,
  output logic             Done_Out
);

  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_d;
  state_e           state_q;
  state_e           state_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;

  logic             cnt_load_s;
  logic             cnt_dec_s;
  logic             len_zero_s;
  logic             last_shift_s;

  // A start is only seen in IDLE; in BURST every enabled edge is a shift.
  assign cnt_load_s = Enable_In && (state_q == IDLE) && Burst_Start_In;
  assign cnt_dec_s  = Enable_In && (state_q == BURST);

  shift_burst_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk_i       (Clk_In),
    .rst_i       (Reset_In),
    .load_i      (cnt_load_s),
    .dec_i       (cnt_dec_s),
    .len_i       (Burst_Len_In),
    .load_zero_o (len_zero_s),
    .last_o      (last_shift_s)
  );

  // Next-state for register, control state and the done pulse.
  always_comb begin
    reg_d   = reg_q;
    state_d = state_q;
    done_d  = 1'b0;   // done is a pulse: cleared on every edge unless re-set
    if (!Enable_In) begin
      reg_d   = reg_q;
      state_d = state_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (Burst_Start_In) begin
            reg_d = Parallel_Data_In;
            if (len_zero_s) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = BURST;
            end
          end else begin
            state_d = IDLE;
            case (Mode_In)
              MODE_HOLD: reg_d = reg_q;
              MODE_SHR:  reg_d = {Serial_Msb_In, reg_q[WIDTH-1:1]};
              MODE_SHL:  reg_d = {reg_q[WIDTH-2:0], Serial_Lsb_In};
              MODE_ROR:  reg_d = {reg_q[0], reg_q[WIDTH-1:1]};
              MODE_ROL:  reg_d = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
              MODE_LOAD: reg_d = Parallel_Data_In;
              default:   reg_d = reg_q;   // reserved encodings hold
            endcase
          end
        end
        BURST: begin
          reg_d = {Serial_Msb_In, reg_q[WIDTH-1:1]};
          if (last_shift_s) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = BURST;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d == BURST);
  end

  // Register, control state and status flags.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      reg_q   <= {WIDTH{1'b0}};
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      reg_q   <= reg_d;
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Parallel_Data_Out = reg_q;
  assign Serial_Lsb_Out    = reg_q[0];
  assign Serial_Msb_Out    = reg_q[WIDTH-1];
  assign Busy_Out          = busy_q;
  assign Done_Out          = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             Clk_In = 1'b0;
  logic             Reset_In;
  logic             Enable_In;
  logic [2:0]       Mode_In;
  logic             Serial_Msb_In;
  logic             Serial_Lsb_In;
  logic [WIDTH-1:0] Parallel_Data_In;
  logic             Burst_Start_In;
  logic [CNT_W-1:0] Burst_Len_In;
  logic [WIDTH-1:0] Parallel_Data_Out;
  logic             Serial_Lsb_Out;
  logic             Serial_Msb_Out;
  logic             Busy_Out;
  logic             Done_Out;

  universal_shift_register #(.WIDTH(WIDTH)) dut (
    .Clk_In            (Clk_In),
    .Reset_In          (Reset_In),
    .Enable_In         (Enable_In),
    .Mode_In           (Mode_In),
    .Serial_Msb_In     (Serial_Msb_In),
    .Serial_Lsb_In     (Serial_Lsb_In),
    .Parallel_Data_In  (Parallel_Data_In),
    .Burst_Start_In    (Burst_Start_In),
    .Burst_Len_In      (Burst_Len_In),
    .Parallel_Data_Out (Parallel_Data_Out),
    .Serial_Lsb_Out    (Serial_Lsb_Out),
    .Serial_Msb_Out    (Serial_Msb_Out),
    .Busy_Out          (Busy_Out),
    .Done_Out          (Done_Out)
  );

  always #5 Clk_In = ~Clk_In;

  typedef struct {
    logic [7:0] data;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   checks = 0;
  int   passes = 0;

  // Monitor: after each rising edge (or an explicit async check) compare
  // every pending expectation against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk_In or chk_ev);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({Parallel_Data_Out, Busy_Out, Done_Out, Serial_Lsb_Out, Serial_Msb_Out} !==
            {e.data, e.busy, e.done, e.data[0], e.data[7]}) begin
          $display("FAIL %s: got data=%h busy=%b done=%b lsb=%b msb=%b, expected data=%h busy=%b done=%b lsb=%b msb=%b",
                   e.name, Parallel_Data_Out, Busy_Out, Done_Out, Serial_Lsb_Out, Serial_Msb_Out,
                   e.data, e.busy, e.done, e.data[0], e.data[7]);
        end else begin
          passes++;
        end
      end
    end
  end

  function automatic exp_t mk(input logic [7:0] d, input logic b, input logic dn, input string nm);
    exp_t e;
    e.data = d;
    e.busy = b;
    e.done = dn;
    e.name = nm;
    return e;
  endfunction

  // One clock: expectation for the state after this rising edge.
  task automatic tick(input logic [7:0] d, input logic b, input logic dn, input string nm);
    @(posedge Clk_In);
    exp_q.push_back(mk(d, b, dn, nm));
    @(negedge Clk_In);
  endtask

  // Check outputs between edges (asynchronous effects).
  task automatic check_now(input logic [7:0] d, input logic b, input logic dn, input string nm);
    exp_q.push_back(mk(d, b, dn, nm));
    -> chk_ev;
    #2;
  endtask

  logic [7:0] shr_exp [8];
  logic [7:0] shl_exp [3];
  logic [7:0] b12_exp [8];

  initial begin
    shr_exp = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    shl_exp = '{8'hFE, 8'hFC, 8'hF8};
    b12_exp = '{8'h5A, 8'h2D, 8'h16, 8'h0B, 8'h05, 8'h02, 8'h01, 8'h00};

    Reset_In         = 1'b1;
    Enable_In        = 1'b1;
    Mode_In          = 3'd0;
    Serial_Msb_In    = 1'b0;
    Serial_Lsb_In    = 1'b0;
    Parallel_Data_In = 8'h00;
    Burst_Start_In   = 1'b0;
    Burst_Len_In     = 4'd0;
    #2;
    check_now(8'h00, 1'b0, 1'b0, "reset_state");
    @(negedge Clk_In);
    Reset_In = 1'b0;

    // Async reset in the middle of a burst
    Mode_In = 3'd5; Parallel_Data_In = 8'hA5;
    tick(8'hA5, 1'b0, 1'b0, "load_a5");
    Mode_In = 3'd0; Burst_Start_In = 1'b1; Burst_Len_In = 4'd3;
    tick(8'hA5, 1'b1, 1'b0, "burst_a5_start");
    Burst_Start_In = 1'b0;
    #1;
    Reset_In = 1'b1;
    check_now(8'h00, 1'b0, 1'b0, "async_reset_midburst");
    tick(8'h00, 1'b0, 1'b0, "reset_held_edge");
    Reset_In = 1'b0;
    Burst_Start_In = 1'b1; Burst_Len_In = 4'd1; Parallel_Data_In = 8'h3C; Serial_Msb_In = 1'b1;
    tick(8'h3C, 1'b1, 1'b0, "restart_after_reset");
    Burst_Start_In = 1'b0;
    tick(8'h9E, 1'b0, 1'b1, "restart_done");
    tick(8'h9E, 1'b0, 1'b0, "restart_idle");

    // Shift right filling ones from 0x00, then shift left filling zeros
    Mode_In = 3'd5; Parallel_Data_In = 8'h00;
    tick(8'h00, 1'b0, 1'b0, "load_00");
    Mode_In = 3'd1; Serial_Msb_In = 1'b1;
    for (int i = 0; i < 8; i++) tick(shr_exp[i], 1'b0, 1'b0, $sformatf("shr_%0d", i));
    Mode_In = 3'd2; Serial_Lsb_In = 1'b0;
    for (int i = 0; i < 3; i++) tick(shl_exp[i], 1'b0, 1'b0, $sformatf("shl_%0d", i));

    // Rotates and reserved modes
    Mode_In = 3'd5; Parallel_Data_In = 8'h81;
    tick(8'h81, 1'b0, 1'b0, "load_81");
    Mode_In = 3'd4;
    tick(8'h03, 1'b0, 1'b0, "rol");
    Mode_In = 3'd3;
    tick(8'h81, 1'b0, 1'b0, "ror_1");
    tick(8'hC0, 1'b0, 1'b0, "ror_2");
    Mode_In = 3'd6;
    tick(8'hC0, 1'b0, 1'b0, "mode6_hold");
    Mode_In = 3'd7;
    tick(8'hC0, 1'b0, 1'b0, "mode7_hold");

    // Burst of 3 from 0xB4; start takes priority over the left-shift mode
    Mode_In = 3'd2; Serial_Msb_In = 1'b0; Parallel_Data_In = 8'hB4;
    Burst_Start_In = 1'b1; Burst_Len_In = 4'd3;
    tick(8'hB4, 1'b1, 1'b0, "b3_start");
    Burst_Start_In = 1'b0;
    tick(8'h5A, 1'b1, 1'b0, "b3_shift1");
    tick(8'h2D, 1'b1, 1'b0, "b3_shift2");
    tick(8'h16, 1'b0, 1'b1, "b3_shift3_done");
    Mode_In = 3'd0;
    tick(8'h16, 1'b0, 1'b0, "b3_after");

    // Zero-length burst
    Burst_Start_In = 1'b1; Burst_Len_In = 4'd0;
    tick(8'hB4, 1'b0, 1'b1, "b0_done");
    Burst_Start_In = 1'b0;
    tick(8'hB4, 1'b0, 1'b0, "b0_after");

    // Length 12 clamps to 8 shifts
    Burst_Start_In = 1'b1; Burst_Len_In = 4'd12;
    tick(8'hB4, 1'b1, 1'b0, "b12_start");
    Burst_Start_In = 1'b0;
    for (int i = 0; i < 7; i++) tick(b12_exp[i], 1'b1, 1'b0, $sformatf("b12_shift%0d", i + 1));
    tick(b12_exp[7], 1'b0, 1'b1, "b12_shift8_done");
    tick(8'h00, 1'b0, 1'b0, "b12_after");

    // Burst of 4 with an enable gap and a dropped start while busy
    Burst_Start_In = 1'b1; Burst_Len_In = 4'd4; Parallel_Data_In = 8'hB4;
    tick(8'hB4, 1'b1, 1'b0, "b4_start");
    Burst_Start_In = 1'b0;
    tick(8'h5A, 1'b1, 1'b0, "b4_shift1");
    tick(8'h2D, 1'b1, 1'b0, "b4_shift2");
    Enable_In = 1'b0;
    tick(8'h2D, 1'b1, 1'b0, "b4_freeze1");
    tick(8'h2D, 1'b1, 1'b0, "b4_freeze2");
    Enable_In = 1'b1; Burst_Start_In = 1'b1; Parallel_Data_In = 8'hFF; Burst_Len_In = 4'd2;
    tick(8'h16, 1'b1, 1'b0, "b4_shift3_start_ignored");
    Burst_Start_In = 1'b0;
    tick(8'h0B, 1'b0, 1'b1, "b4_shift4_done");
    Enable_In = 1'b0;
    tick(8'h0B, 1'b0, 1'b0, "done_clears_when_disabled");
    Enable_In = 1'b1;
    tick(8'h0B, 1'b0, 1'b0, "no_second_done");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge Clk_In);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
